// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: a CPU write to DMA_REG_ADDR halts the CPU and copies one
// page into the OAM data port as alternating read/write bus cycles.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [7:0]  mem_din,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_rw,
    output logic        dma_busy
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state, state_n;
    logic [7:0] idx;
    logic [7:0] page;
    logic [7:0] data_q;
    logic       cyc_odd;
    logic       trigger;
    logic       last;

    assign trigger = (state == IDLE) && !cpu_rw && (cpu_addr == DMA_REG_ADDR);
    assign last    = (idx == LAST_IDX);

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 8'd0;
            page    <= 8'd0;
            data_q  <= 8'd0;
            cyc_odd <= 1'b0;
        end else begin
            state   <= state_n;
            cyc_odd <= ~cyc_odd;
            if (trigger)
                page <= cpu_dout;
            if (state == READ)
                data_q <= mem_din;
            if (state == WRITE)
                idx <= last ? 8'd0 : idx + 8'd1;
        end
    end

    // The CPU owns the bus except in READ/WRITE; the halted dummy read picks the
    // alignment so every DMA read lands on an even cycle.
    always_comb begin
        state_n  = state;
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_rw   = cpu_rw;
        case (state)
            IDLE: begin
                if (trigger)
                    state_n = HALT;
            end
            HALT: begin
                if (cpu_rw)
                    state_n = cyc_odd ? READ : ALIGN;
            end
            ALIGN: state_n = READ;
            READ: begin
                bus_addr = {page, idx};
                bus_rw   = 1'b1;
                bus_dout = 8'd0;
                state_n  = WRITE;
            end
            WRITE: begin
                bus_addr = OAM_DATA_ADDR;
                bus_rw   = 1'b0;
                bus_dout = data_q;
                state_n  = last ? IDLE : READ;
            end
            default: state_n = IDLE;
        endcase
    end

    assign cpu_rdy  = (state == IDLE);
    assign dma_busy = (state != IDLE);

endmodule
